pipelined_adder_tree: RTL and testbench



---
 rtl/pipelined_adder_tree.sv | 147 ++++++++++++++
 tb/tb_pipelined_adder_tree.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_tree.sv
// Signed pipelined binary adder tree followed by a multi-beat group accumulator.
// Define PIPELINED_ADDER_TREE_SAT_EN for a saturating accumulator; by default it wraps.
module pipelined_adder_tree #(
    parameter int IN_WIDTH         = 8,
    parameter int NUM              = 16,
    parameter int OUT_WIDTH        = 32,
    parameter int LEVELS_PER_STAGE = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM*IN_WIDTH-1:0]     in_data,
    input  logic                        in_valid,
    input  logic                        in_last,
    output logic                        in_ready,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int L      = $clog2(NUM);
    localparam int S      = (L + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;
    localparam int TREE_W = IN_WIDTH + L;

    function automatic int nodes_at(input int lv);
        int n;
        n = NUM;
        for (int i = 0; i < lv; i++) n = (n + 1) / 2;
        return n;
    endfunction

    logic                        en;
    logic [S-1:0]                vld_q;
    logic [S-1:0]                lst_q;
    logic signed [TREE_W-1:0]    tree_sum;
    logic signed [OUT_WIDTH-1:0] acc_sum;
    logic signed [OUT_WIDTH-1:0] acc_q, acc_d;
    logic signed [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                        out_valid_q, out_valid_d;

    // A result parked at the output without a taker freezes the whole datapath.
    assign en       = !(out_valid_q && !out_ready);
    assign in_ready = en;

    // Level lv holds nodes_at(lv) values of exactly IN_WIDTH+lv bits; level 0 is the input.
    for (genvar lv = 0; lv <= L; lv++) begin : g_lvl
        localparam int  N   = nodes_at(lv);
        localparam int  W   = IN_WIDTH + lv;
        localparam bit  REG = (lv > 0) && ((lv % LEVELS_PER_STAGE == 0) || (lv == L));

        logic signed [W-1:0] sum_d [N];
        logic signed [W-1:0] node  [N];

        for (genvar k = 0; k < N; k++) begin : g_node
            if (lv == 0) begin : g_leaf
                assign sum_d[k] = in_data[k*IN_WIDTH +: IN_WIDTH];
            end else if (2*k+1 < nodes_at(lv-1)) begin : g_pair
                assign sum_d[k] = W'(g_lvl[lv-1].node[2*k]) + W'(g_lvl[lv-1].node[2*k+1]);
            end else begin : g_pass
                assign sum_d[k] = W'(g_lvl[lv-1].node[2*k]);
            end

            if (REG) begin : g_reg
                logic signed [W-1:0] node_q;
                // NOTE: tree data flops carry no reset; the stage valid bits mark them don't-care after reset.
                always_ff @(posedge clk) begin
                    if (en) node_q <= sum_d[k];
                end
                assign node[k] = node_q;
            end else begin : g_wire
                assign node[k] = sum_d[k];
            end
        end
    end

    assign tree_sum = g_lvl[L].node[0];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            lst_q <= '0;
        end else if (en) begin
            vld_q[0] <= in_valid;
            lst_q[0] <= in_valid && in_last;
            for (int s = 1; s < S; s++) begin
                vld_q[s] <= vld_q[s-1];
                lst_q[s] <= lst_q[s-1];
            end
        end
    end

`ifdef PIPELINED_ADDER_TREE_SAT_EN
    localparam int WIDE_W = OUT_WIDTH + 1;
    localparam logic signed [WIDE_W-1:0] SAT_MAX = {2'b00, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [WIDE_W-1:0] SAT_MIN = {2'b11, {(OUT_WIDTH-1){1'b0}}};

    logic signed [WIDE_W-1:0] wide_sum;

    always_comb begin
        wide_sum = WIDE_W'(acc_q) + WIDE_W'(tree_sum);
        if (wide_sum > SAT_MAX) begin
            acc_sum = SAT_MAX[OUT_WIDTH-1:0];
        end else if (wide_sum < SAT_MIN) begin
            acc_sum = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            acc_sum = wide_sum[OUT_WIDTH-1:0];
        end
    end
`else
    assign acc_sum = acc_q + OUT_WIDTH'(tree_sum);
`endif

    // NOTE: every output gets a default first so this block cannot infer a latch.
    always_comb begin
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (en) begin
            out_valid_d = 1'b0;
            if (vld_q[S-1]) begin
                if (lst_q[S-1]) begin
                    out_data_d  = acc_sum;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                end else begin
                    acc_d = acc_sum;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Directed bench for pipelined_adder_tree: default build, a 12-bit accumulator
// instance (wrap or saturate by macro) and an odd-width NUM=5 instance.
module tb_pipelined_adder_tree;

    localparam int IW  = 8;
    localparam int NUM = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NUM*IW-1:0]  in_data;
    logic               in_valid, in_last, in_ready;
    logic signed [31:0] out_data;
    logic               out_valid, out_ready;

    logic [NUM*IW-1:0]  w_in_data;
    logic               w_in_valid, w_in_last, w_in_ready;
    logic signed [11:0] w_out_data;
    logic               w_out_valid;

    logic [5*IW-1:0]    o_in_data;
    logic               o_in_valid, o_in_last, o_in_ready;
    logic signed [31:0] o_out_data;
    logic               o_out_valid;

    int n_checks = 0;
    int n_errors = 0;

    pipelined_adder_tree #(.IN_WIDTH(IW), .NUM(NUM), .OUT_WIDTH(32), .LEVELS_PER_STAGE(1)) u_dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    pipelined_adder_tree #(.IN_WIDTH(IW), .NUM(NUM), .OUT_WIDTH(12), .LEVELS_PER_STAGE(1)) u_dut_w12 (
        .clk(clk), .rst(rst),
        .in_data(w_in_data), .in_valid(w_in_valid), .in_last(w_in_last), .in_ready(w_in_ready),
        .out_data(w_out_data), .out_valid(w_out_valid), .out_ready(1'b1)
    );

    pipelined_adder_tree #(.IN_WIDTH(IW), .NUM(5), .OUT_WIDTH(32), .LEVELS_PER_STAGE(2)) u_dut_odd (
        .clk(clk), .rst(rst),
        .in_data(o_in_data), .in_valid(o_in_valid), .in_last(o_in_last), .in_ready(o_in_ready),
        .out_data(o_out_data), .out_valid(o_out_valid), .out_ready(1'b1)
    );

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [NUM*IW-1:0] fill(input int v);
        logic [NUM*IW-1:0] r;
        for (int k = 0; k < NUM; k++) r[k*IW +: IW] = IW'(v);
        return r;
    endfunction

    task automatic beat(input logic [NUM*IW-1:0] d, input logic last);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic signed [31:0] exp);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, out_valid, 1);
        check(tag, out_data, exp);
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        logic [NUM*IW-1:0] mixed;

        rst = 1'b1;
        in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        w_in_data = '0; w_in_valid = 1'b0; w_in_last = 1'b0;
        o_in_data = '0; o_in_valid = 1'b0; o_in_last = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1);

        // Single beat of all ones: S+1 = 5 clock edges counting the accepting edge.
        in_data = fill(1); in_valid = 1'b1; in_last = 1'b1;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        idle();
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check("latency", cyc, 5);
        check("single_sum", out_data, 16);
        @(negedge clk);
        check("pulse_one_cycle", out_valid, 0);

        beat(fill(-128), 1'b1); idle();
        expect_out("all_min", -2048);
        beat(fill(127), 1'b1); idle();
        expect_out("all_max", 2032);

        // Elements k-8 for k=0..15: 120 - 128 = -8.
        for (int k = 0; k < NUM; k++) mixed[k*IW +: IW] = IW'(k - 8);
        beat(mixed, 1'b1); idle();
        expect_out("mixed", -8);

        in_valid = 1'b0; in_last = 1'b1;
        repeat (3) @(negedge clk);
        check("ghost_last", out_valid, 0);
        in_last = 1'b0;
        beat(fill(1), 1'b0); beat(fill(2), 1'b1); idle();
        expect_out("two_beat", 48);

        // 16+32+48 = 96, then a single-beat group 5*16 = 80 on the very next cycle.
        beat(fill(1), 1'b0); beat(fill(2), 1'b0); beat(fill(3), 1'b1); beat(fill(5), 1'b1); idle();
        expect_out("group3", 96);
        check("b2b_valid", out_valid, 1);
        check("b2b_sum", out_data, 80);
        @(negedge clk);
        check("b2b_end", out_valid, 0);

        out_ready = 1'b0;
        beat(fill(1), 1'b1); beat(fill(2), 1'b1); beat(fill(3), 1'b1); beat(fill(4), 1'b1); idle();
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("bp_first_valid", out_valid, 1);
        check("bp_first", out_data, 16);
        check("bp_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_data", out_data, 16);
            check("bp_hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, 16 * i);
            @(negedge clk);
        end
        check("bp_no_dup", out_valid, 0);

        beat(fill(7), 1'b0); beat(fill(7), 1'b0); idle();
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", out_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", in_ready, 1);
        beat(fill(1), 1'b1); idle();
        expect_out("after_rst", 16);

        // Two beats of 16*127: 4064, beyond the 12-bit signed range.
        w_in_data = fill(127); w_in_valid = 1'b1; w_in_last = 1'b0;
        @(negedge clk);
        w_in_last = 1'b1;
        @(negedge clk);
        w_in_valid = 1'b0; w_in_last = 1'b0;
        cyc = 0;
        while (!w_out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("w12_valid", w_out_valid, 1);
`ifdef PIPELINED_ADDER_TREE_SAT_EN
        check("w12_sat", w_out_data, 2047);
`else
        check("w12_wrap", w_out_data, -32);
`endif

        // NUM=5, two levels per stage: S = 2, latency 3, sum 15.
        o_in_data = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}; o_in_valid = 1'b1; o_in_last = 1'b1;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        o_in_valid = 1'b0; o_in_last = 1'b0;
        while (!o_out_valid && cyc < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check("odd_latency", cyc, 3);
        check("odd_sum", o_out_data, 15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
